// File: rtl/slice_accumulator.sv
// Slices a captured wide word LSB-first onto a valid/ready stream and sums the slices.
// Define SLICE_ACC_SIGNED_EN to sign-extend slices into a two's-complement sum.
module slice_accumulator #(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH-1:0]                         in_word,
  input  logic [$clog2(WIDTH/SLICE):0]             in_count,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [SLICE-1:0]                         out_slice,
  output logic [$clog2(WIDTH/SLICE)-1:0]           out_index,
  output logic                                     out_last,
  output logic                                     sum_valid,
  output logic [SLICE+$clog2(WIDTH/SLICE)-1:0]     sum
);
  localparam int N    = WIDTH / SLICE;
  localparam int IW   = $clog2(N);
  localparam int CW   = IW + 1;
  localparam int SUMW = SLICE + IW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] SUM  = 2'd2;

  logic [1:0]               state;
  logic [WIDTH-1:0]         word_q;
  logic [CW-1:0]            count_q;
  logic [IW-1:0]            idx;
  logic [SUMW-1:0]          acc, sum_q, slice_ext;
  logic [N-1:0][SLICE-1:0]  slices;
  logic [CW-1:0]            eff_count;
  logic                     emit;

  // packed view of the word: slices[idx] is word_q[SLICE*idx +: SLICE]
  assign slices    = word_q;
  assign emit      = (state == EMIT);
  assign in_ready  = (state == IDLE);
  assign out_valid = emit;
  assign out_slice = emit ? slices[idx] : '0;
  assign out_index = emit ? idx : '0;
  assign out_last  = emit && (CW'(idx) == count_q - CW'(1));
  assign eff_count = (in_count == '0 || in_count > CW'(N)) ? CW'(N) : in_count;

`ifdef SLICE_ACC_SIGNED_EN
  assign slice_ext = {{(SUMW-SLICE){out_slice[SLICE-1]}}, out_slice};
`else
  assign slice_ext = {{(SUMW-SLICE){1'b0}}, out_slice};
`endif

  // The SUM cycle presents the fresh total; a flush in that cycle suppresses it.
  assign sum_valid = (state == SUM) && !flush;
  assign sum       = sum_valid ? acc : sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      word_q  <= '0;
      count_q <= '0;
      idx     <= '0;
      acc     <= '0;
      sum_q   <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          word_q  <= in_word;
          count_q <= eff_count;
          idx     <= '0;
          acc     <= '0;
          state   <= EMIT;
        end
        EMIT: if (out_ready) begin
          acc <= acc + slice_ext;
          if (out_last) state <= SUM;
          else          idx   <= idx + IW'(1);
        end
        SUM: begin
          sum_q <= acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slice_accumulator.sv
// Randomized bench for slice_accumulator against a slice-sum reference model.
module tb_slice_accumulator;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] in_word = '0;
  logic [3:0]  in_count = '0;
  logic        in_ready, out_valid, out_last, sum_valid;
  logic [7:0]  out_slice;
  logic [2:0]  out_index;
  logic [10:0] sum;

  int          vecs = 0, errs = 0;
  logic [10:0] last_sum = '0;

  slice_accumulator #(.WIDTH(64), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_count(in_count), .out_valid(out_valid), .out_ready(out_ready),
    .out_slice(out_slice), .out_index(out_index), .out_last(out_last),
    .sum_valid(sum_valid), .sum(sum)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] model_sum(input logic [63:0] w, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) begin
`ifdef SLICE_ACC_SIGNED_EN
      byte b;
      b = w[8*i +: 8];
      s += b;
`else
      s += int'(w[8*i +: 8]);
`endif
    end
    return 11'(s);
  endfunction

  function automatic int eff_of(input logic [3:0] c);
    return (c == 0 || c > 8) ? 8 : int'(c);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [63:0] w, input logic [3:0] c);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin step(); t++; end
    vecs++;
    if (in_ready !== 1'b1) begin errs++; $display("FAIL accept_wait in_ready=%b required 1", in_ready); end
    in_word = w; in_count = c; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_word = {$urandom, $urandom}; in_count = 4'($urandom);
  endtask

  // mode 0: always ready, 1: random ready + stray in_valid, 2: 3-cycle stall at index 2
  task automatic stream(input logic [63:0] w, input logic [3:0] c, input int mode);
    int eff = eff_of(c);
    int i = 0, stall = 0, guard = 0;
    logic r;
    logic [10:0] es = model_sum(w, eff);
    logic [14:0] act, exp;
    while (i < eff && guard < 200) begin
      act = {out_valid, out_slice, out_index, out_last, sum_valid, in_ready};
      exp = {1'b1, w[8*i +: 8], 3'(i), (i == eff - 1), 1'b0, 1'b0};
      vecs++;
      if (act !== exp) begin errs++; $display("FAIL stream i=%0d got=%h required=%h", i, act, exp); end
      case (mode)
        0: r = 1'b1;
        1: begin r = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1)); end
        default: begin r = !(i == 2 && stall < 3); if (!r) stall++; end
      endcase
      out_ready = r;
      step();
      if (r) i++;
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
    vecs++;
    if (guard >= 200) begin errs++; $display("FAIL stream_timeout slices=%0d required %0d", i, eff); end
    vecs++;
    if ({sum_valid, in_ready, out_valid, sum} !== {3'b100, es})
      begin errs++; $display("FAIL sum_pulse got v/r/o=%b%b%b sum=%h required 100 sum=%h", sum_valid, in_ready, out_valid, sum, es); end
    step();
    vecs++;
    if ({sum_valid, in_ready, sum} !== {2'b01, es})
      begin errs++; $display("FAIL sum_hold got v/r=%b%b sum=%h required 01 sum=%h", sum_valid, in_ready, sum, es); end
    last_sum = es;
  endtask

  task automatic test_reset();
    #3;
    vecs++;
    if ({out_valid, out_slice, out_index, out_last, sum_valid, in_ready, sum} !== {15'b000000000000001, 11'h0})
      begin errs++; $display("FAIL reset_state got v=%b s=%h i=%h l=%b sv=%b r=%b sum=%h", out_valid, out_slice, out_index, out_last, sum_valid, in_ready, sum); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    accept(64'h0807060504030201, 4'd0);
    stream(64'h0807060504030201, 4'd0, 0);
    vecs++;
    if (sum !== 11'h024) begin errs++; $display("FAIL basic_sum got=%h required=024", sum); end
  endtask

  task automatic test_all_ones();
    logic [10:0] want;
`ifdef SLICE_ACC_SIGNED_EN
    want = 11'h7FD;
`else
    want = 11'h2FD;
`endif
    accept({64{1'b1}}, 4'd3);
    stream({64{1'b1}}, 4'd3, 0);
    vecs++;
    if (sum !== want) begin errs++; $display("FAIL ones_sum got=%h required=%h", sum, want); end
  endtask

  task automatic test_backpressure();
    accept(64'h0807060504030201, 4'd0);
    stream(64'h0807060504030201, 4'd0, 2);
    vecs++;
    if (sum !== 11'h024) begin errs++; $display("FAIL stall_sum got=%h required=024", sum); end
  endtask

  task automatic test_clamp();
    logic [63:0] w = {$urandom, $urandom};
    accept(w, 4'd12);
    stream(w, 4'd12, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      logic [63:0] w = {$urandom, $urandom};
      logic [3:0]  c = 4'($urandom_range(0, 15));
      accept(w, c);
      stream(w, c, 1);
    end
  endtask

  task automatic test_flush();
    logic [63:0] w = {$urandom, $urandom};
    accept(w, 4'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    vecs++;
    if (out_index !== 3'd4) begin errs++; $display("FAIL flush_pos got=%0d required 4", out_index); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vecs++;
    if ({out_valid, in_ready, sum_valid, sum} !== {3'b010, last_sum})
      begin errs++; $display("FAIL flush_abort got o/r/sv=%b%b%b sum=%h required 010 sum=%h", out_valid, in_ready, sum_valid, sum, last_sum); end
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++;
      if ({sum_valid, sum} !== {1'b0, last_sum})
        begin errs++; $display("FAIL flush_quiet got sv=%b sum=%h required 0 sum=%h", sum_valid, sum, last_sum); end
    end
    w = {$urandom, $urandom};
    accept(w, 4'd5);
    stream(w, 4'd5, 0);
  endtask

  task automatic test_async_reset();
    logic [63:0] w = {$urandom, $urandom};
    accept(w, 4'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    vecs++;
    if (out_index !== 3'd5) begin errs++; $display("FAIL areset_pos got=%0d required 5", out_index); end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({out_valid, out_slice, out_index, out_last, sum_valid, in_ready, sum} !== {15'b000000000000001, 11'h0})
      begin errs++; $display("FAIL areset_now got v=%b s=%h i=%h l=%b sv=%b r=%b sum=%h", out_valid, out_slice, out_index, out_last, sum_valid, in_ready, sum); end
    step();
    rst_n = 1'b1;
    last_sum = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++;
      if ({sum_valid, in_ready, out_valid, sum} !== {3'b010, 11'h0})
        begin errs++; $display("FAIL areset_after got sv/r/o=%b%b%b sum=%h required 010 sum=000", sum_valid, in_ready, out_valid, sum); end
    end
    w = {$urandom, $urandom};
    accept(w, 4'd2);
    stream(w, 4'd2, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_backpressure();
    test_clamp();
    test_random();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/slice_accumulator.md
Name: slice_accumulator

Overview:
- Sequences an indexed part-select datapath (`word[SLICE*sel +: SLICE]`) over a captured wide word.
- Emits slices LSB-first over a valid/ready stream and accumulates them into a width-grown sum.
- Sits between a wide-word producer and a narrow consumer (byte serializer, checksum unit).
- Owns the select counter, the handshakes and the zero/sign extension of slices into the accumulator.

Parameters:
- WIDTH, 64, input word width; must equal SLICE*N.
- SLICE, 8, slice width in bits.
- N (localparam), WIDTH/SLICE, slices per word; must be a power of two, ≥2.
- IW (localparam), $clog2(N), slice index width.
- CW (localparam), $clog2(N)+1, slice count width.
- SUMW (localparam), SLICE+$clog2(N), accumulator width; holds N full-scale slices without overflow.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the word in flight.
- in_valid  in  1  word available.
- in_ready  out  1  block idle and accepting.
- in_word  in  WIDTH  word to slice.
- in_count  in  CW  number of slices to emit; 0 or >N means N.
- out_valid  out  1  slice valid.
- out_ready  in  1  consumer accepts slice.
- out_slice  out  SLICE  current slice.
- out_index  out  IW  select index of current slice.
- out_last  out  1  current slice is the final one.
- sum_valid  out  1  one-cycle pulse; sum updated.
- sum  out  SUMW  accumulated slice sum.

Behaviour:
- States: IDLE, EMIT, SUM.
- in_ready = (state==IDLE), combinational.
- Reset (async, rst_n=0):
  - state=IDLE, so in_ready=1.
  - out_valid=0, out_slice=0, out_index=0, out_last=0.
  - sum_valid=0, sum=0.
  - Accumulator, captured word and count cleared.
- IDLE, on in_valid&&in_ready:
  - Capture in_word and the effective count (clamped to 1..N).
  - idx=0, acc=0.
  - Go to EMIT; first slice is valid the next cycle.
- EMIT outputs:
  - out_valid=1.
  - out_slice=word_q[SLICE*idx +: SLICE].
  - out_index=idx.
  - out_last=(idx==count_q-1).
- EMIT, on out_valid&&out_ready:
  - acc <= acc + zext(out_slice) to SUMW bits.
  - If out_last: go to SUM. Otherwise idx <= idx+1.
- EMIT, with out_ready=0: out_slice, out_index and out_last are held stable; acc is unchanged.
- SUM:
  - sum <= final acc and sum_valid=1 for exactly one cycle.
  - Return to IDLE.
  - sum holds its value until the next SUM state.
- Latency:
  - Accept at cycle t, first slice at t+1.
  - sum_valid one cycle after the last slice handshake.
  - Minimum word period is count+2 cycles.
- Arithmetic:
  - Unsigned, modulo 2^SUMW.
  - No overflow is possible for count ≤ N.
- flush:
  - In EMIT or SUM: next state IDLE, out_valid=0, no sum_valid pulse, sum keeps its previous value.
  - In IDLE: no effect.
  - flush has priority over a simultaneous out handshake.
- in_valid is ignored outside IDLE; the word is not queued.
- Async reset mid-word: word discarded, no sum_valid, all outputs return to reset values immediately.

Optional Feature:
- Macro: SLICE_ACC_SIGNED_EN.
- When defined:
  - Each slice is treated as signed and sign-extended (`$signed`) to SUMW before accumulation.
  - sum is two's complement.
  - Range N*(-2^(SLICE-1))..N*(2^(SLICE-1)-1) fits SUMW bits.
- When undefined: zero-extension, unsigned sum.
- Stream outputs (out_slice, out_index, out_last) are identical in both builds.

Test Plan:
1. Defaults, in_word=64'h0807060504030201, in_count=0, out_ready=1 → out_slice 01..08 on indices 0..7; out_last only at index 7; sum_valid one cycle later with sum=11'h024.
2. in_word all ones, in_count=3 → three slices 8'hFF, indices 0..2, out_last at index 2; unsigned build sum=11'h2FD, SLICE_ACC_SIGNED_EN build sum=11'h7FD (-3).
3. Backpressure: out_ready=0 for 3 cycles at index 2 → out_slice/out_index stable; final sum equals the no-stall case (11'h024 for the case-1 word); in_ready stays 0.
4. in_count=12 → clamped; exactly 8 slices emitted, out_last at index 7.
5. flush asserted while out_index=4 with out_ready=1 → next cycle out_valid=0, in_ready=1; no sum_valid; sum keeps prior value; next word accepted normally.
6. rst_n low mid-EMIT at index 5 → outputs zero immediately, in_ready=1 after release; no sum_valid; sum=0.
